// File: rtl/core_pkg.sv
// Shared register-file constants and types for the writeback path.
package core_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from an internal
// pointer that moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          found;
  int            idx;

  // First requester at or after the pointer, wrapping past the top index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[PW-1:0];
      end
    end
  end

  // Pointer steps to the slot after the winner only when a grant is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      if (grant_idx == PW'(NUM_REQ - 1)) rr_ptr <= '0;
      else                               rr_ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates writeback requesters onto
// the single write port and tracks in-flight destinations for hazard stalls.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int REG_AW  = core_pkg::REG_AW,
  parameter int DATA_W  = core_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_AW-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_reg_write,
  output logic [REG_AW-1:0]         rf_write_reg,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      issue_rd_en,
  input  logic [REG_AW-1:0]         issue_rs1,
  input  logic [REG_AW-1:0]         issue_rs2,
  output logic                      issue_stall,
  output logic [31:0]               busy_mask
);

  import core_pkg::*;

  logic              handshake;
  logic [REG_AW-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sb_set;
  logic [31:0]       busy_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (handshake),
    .grant   (req_ready)
  );

  assign handshake = |(req_valid & req_ready);

  // Route the granted requester's address and data toward the write register.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_reg  = req_reg[i*REG_AW +: REG_AW];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-cycle write stage; x0 writes are accepted but never enable the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else if (handshake) begin
      rf_reg_write  <= (sel_reg != REG_AW'(REG_ZERO));
      rf_write_reg  <= sel_reg;
      rf_write_data <= sel_data;
    end else begin
      rf_reg_write  <= 1'b0;
    end
  end

  // Hold issue while any source or the destination still has a write in flight.
  always_comb begin
    issue_stall = issue_valid &&
                  (((issue_rs1 != '0) && busy_mask[issue_rs1]) ||
                   ((issue_rs2 != '0) && busy_mask[issue_rs2]) ||
                   (issue_rd_en && (issue_rd != '0) && busy_mask[issue_rd]));
  end

  assign sb_set = issue_valid && !issue_stall && issue_rd_en && (issue_rd != '0);

  // Commit clears the register, a new producer sets it, and the set wins a tie.
  always_comb begin
    busy_next = busy_mask;
    if (rf_reg_write) busy_next[rf_write_reg] = 1'b0;
    if (sb_set)       busy_next[issue_rd]     = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_next;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised self-checking bench for regfile_wb_scheduler with a
// behavioural model of arbitration, write timing and the scoreboard.
module tb_regfile_wb_scheduler;

  localparam int N = 3;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_reg;
  logic [N*32-1:0] req_data;
  logic            rf_reg_write;
  logic [4:0]      rf_write_reg;
  logic [31:0]     rf_write_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_rd_en;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic            issue_stall;
  logic [31:0]     busy_mask;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit [31:0] m_busy;
  int        m_ptr;
  bit        m_we;
  bit [4:0]  m_reg;
  bit [31:0] m_data;

  logic [N-1:0] last_ready;
  logic         last_stall;

  regfile_wb_scheduler #(.NUM_REQ(N), .REG_AW(5), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rd_en   (issue_rd_en),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_stall   (issue_stall),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_reg     = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_rd_en = 1'b0;
    issue_rs1   = '0;
    issue_rs2   = '0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_output("rst_we",   rf_reg_write,  0);
    check_output("rst_busy", busy_mask,     0);
    check_output("rst_reg",  rf_write_reg,  0);
    check_output("rst_data", rf_write_data, 0);
    #2;
    reset  = 1'b0;
    m_busy = '0;
    m_ptr  = 0;
    m_we   = 1'b0;
    m_reg  = '0;
    m_data = '0;
  endtask

  // One clock: check combinational outputs before the edge, then advance
  // the model and check registered outputs after it.
  task automatic apply_stimulus();
    int         g;
    int         idx;
    logic [N-1:0] er;
    bit         es;
    bit [31:0]  nb;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    es = issue_valid && ((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                         (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                         (issue_rd_en && issue_rd != 0 && m_busy[issue_rd]));
    check_output("ready", req_ready, er);
    check_output("stall", issue_stall, es);
    last_ready = req_ready;
    last_stall = issue_stall;
    @(posedge clk);
    #1;
    nb = m_busy;
    if (m_we) nb[m_reg] = 1'b0;
    if (issue_valid && !es && issue_rd_en && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    if (g >= 0) begin
      m_reg  = req_reg[g*5 +: 5];
      m_data = req_data[g*32 +: 32];
      m_we   = (m_reg != 0);
      m_ptr  = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    check_output("wr_en",   rf_reg_write,  m_we);
    check_output("wr_reg",  rf_write_reg,  m_reg);
    check_output("wr_data", rf_write_data, m_data);
    check_output("busy",    busy_mask,     m_busy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    #6;
    do_reset();
    apply_stimulus();
    check_output("idle_ready", last_ready, 0);

    // Single write
    req_valid = 3'b001;
    req_reg[4:0]   = 5'd5;
    req_data[31:0] = 32'hDEADBEEF;
    apply_stimulus();
    check_output("single_ready", last_ready, 3'b001);
    check_output("single_we",    rf_reg_write, 1);
    check_output("single_reg",   rf_write_reg, 5);
    check_output("single_data",  rf_write_data, 32'hDEADBEEF);

    // Round-robin fairness from a fresh pointer
    clear_inputs();
    do_reset();
    req_valid = 3'b111;
    req_reg   = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    for (int k = 0; k < 6; k++) begin
      apply_stimulus();
      check_output("fair_gnt", last_ready, 3'b001 << (k % 3));
      check_output("fair_reg", rf_write_reg, (k % 3) + 1);
      check_output("fair_we",  rf_reg_write, 1);
    end

    // x0 write is accepted but never enables the port
    clear_inputs();
    req_valid      = 3'b001;
    req_data[31:0] = 32'h1234;
    apply_stimulus();
    check_output("x0_ready", last_ready, 3'b001);
    check_output("x0_we",    rf_reg_write, 0);

    // RAW hazard on r7
    clear_inputs();
    do_reset();
    issue_valid = 1'b1;
    issue_rd_en = 1'b1;
    issue_rd    = 5'd7;
    apply_stimulus();
    check_output("raw_set_stall", last_stall, 0);
    check_output("raw_busy7",     busy_mask[7], 1);
    issue_rd_en = 1'b0;
    issue_rd    = 5'd0;
    issue_rs1   = 5'd7;
    apply_stimulus();
    check_output("raw_hold1", last_stall, 1);
    req_valid      = 3'b100;
    req_reg[14:10] = 5'd7;
    req_data[95:64] = 32'hCAFE0007;
    apply_stimulus();
    check_output("raw_hold_hs", last_stall, 1);
    req_valid = 3'b000;
    apply_stimulus();
    check_output("raw_hold_commit", last_stall, 1);
    apply_stimulus();
    check_output("raw_release", last_stall, 0);
    issue_rs1 = 5'd0;
    apply_stimulus();
    check_output("raw_x0_src", last_stall, 0);

    // Commit and new producer of r9 on the same edge: set wins
    clear_inputs();
    req_valid      = 3'b001;
    req_reg[4:0]   = 5'd9;
    req_data[31:0] = 32'h99;
    apply_stimulus();
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    issue_rd_en = 1'b1;
    issue_rd    = 5'd9;
    apply_stimulus();
    check_output("tie_stall", last_stall, 0);
    check_output("tie_busy9", busy_mask[9], 1);
    apply_stimulus();
    check_output("waw_stall", last_stall, 1);

    // Reset while a write is registered
    clear_inputs();
    issue_valid = 1'b1;
    issue_rd_en = 1'b1;
    issue_rd    = 5'd4;
    apply_stimulus();
    clear_inputs();
    req_valid     = 3'b010;
    req_reg[9:5]  = 5'd4;
    req_data[63:32] = 32'h44;
    apply_stimulus();
    check_output("mid_we_pre", rf_reg_write, 1);
    do_reset();
    req_valid = 3'b111;
    apply_stimulus();
    check_output("post_rst_gnt", last_ready, 3'b001);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid   = 3'($urandom_range(0, 7));
      req_reg     = 15'($urandom);
      req_data    = {$urandom, $urandom, $urandom};
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd_en = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      apply_stimulus();
      if (c % 97 == 96) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
